// File: rtl/des_decrypt_core.sv
// des_decrypt_core: iterative DES block decryptor, RPC (1 or 2) rounds per clock.
// Optional DES_ENC_EN adds an 'encrypt' input selecting the forward key schedule.
module des_decrypt_core #(
    parameter int RPC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] data_in,
    input  logic [63:0] key_in,
    output logic        out_valid,
    input  logic        out_ready,
`ifdef DES_ENC_EN
    input  logic        encrypt,
`endif
    output logic [63:0] data_out
);

    // Tables hold 1-based DES bit numbers; bit n lives at index n-1.
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int IPI_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};

    localparam int E_T [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9,
        8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};

    localparam int P_T [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
        23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    localparam int SBOX [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
          0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
          3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
          1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
          3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
          4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
          6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
          1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
          2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

    typedef struct packed {
        logic [31:0] l;
        logic [31:0] r;
        logic [27:0] c;
        logic [27:0] d;
    } blk_t;

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[i] = x[6'(IP_T[i] - 1)];
        return y;
    endfunction

    function automatic logic [63:0] perm_ipinv(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[i] = x[6'(IPI_T[i] - 1)];
        return y;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[i] = x[6'(PC1_T[i] - 1)];
        return y;
    endfunction

    function automatic logic [1:0] shamt(input logic [3:0] rnd, input logic fwd);
        logic [1:0] n;
        unique case (rnd)
            4'd0:              n = fwd ? 2'd1 : 2'd0;
            4'd1, 4'd8, 4'd15: n = 2'd1;
            default:           n = 2'd2;
        endcase
        return n;
    endfunction

    // A DES left rotate moves bits toward DES bit 1, i.e. toward index 0.
    function automatic logic [27:0] rot(input logic [27:0] x, input logic [1:0] n,
                                        input logic fwd);
        logic [27:0] y;
        y = x;
        if (fwd) begin
            if (n == 2'd1)      y = {x[0], x[27:1]};
            else if (n == 2'd2) y = {x[1:0], x[27:2]};
        end else begin
            if (n == 2'd1)      y = {x[26:0], x[27]};
            else if (n == 2'd2) y = {x[25:0], x[27:26]};
        end
        return y;
    endfunction

    function automatic blk_t round_f(input blk_t b, input logic [3:0] rnd, input logic fwd);
        blk_t        o;
        logic [55:0] cd;
        logic [47:0] k;
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] f;
        logic [5:0]  six;
        logic [3:0]  v;
        o.c = rot(b.c, shamt(rnd, fwd), fwd);
        o.d = rot(b.d, shamt(rnd, fwd), fwd);
        cd  = {o.d, o.c};
        for (int n = 0; n < 48; n++) k[n] = cd[6'(PC2_T[n] - 1)];
        for (int n = 0; n < 48; n++) x[n] = b.r[5'(E_T[n] - 1)] ^ k[n];
        for (int j = 0; j < 8; j++) begin
            six = x[6*j +: 6];
            v   = 4'(SBOX[j][{six[0], six[5], six[1], six[2], six[3], six[4]}]);
            s[4*j +: 4] = {v[0], v[1], v[2], v[3]};
        end
        for (int n = 0; n < 32; n++) f[n] = s[5'(P_T[n] - 1)];
        o.l = b.r;
        o.r = b.l ^ f;
        return o;
    endfunction

    state_t      state_q;
    state_t      state_nx;
    blk_t        blk_q;
    blk_t        blk_mid;
    blk_t        blk_nx;
    logic [3:0]  cnt_q;
    logic        fwd_q;
    logic        last;
    logic [63:0] ip_o;
    logic [55:0] pc1_o;

    assign ip_o    = perm_ip(data_in);
    assign pc1_o   = perm_pc1(key_in);
    assign last    = (cnt_q == 4'(16 - RPC));
    assign blk_mid = round_f(blk_q, cnt_q, fwd_q);

    if (RPC == 2) begin : g_rpc2
        assign blk_nx = round_f(blk_mid, cnt_q + 4'd1, fwd_q);
    end else begin : g_rpc1
        assign blk_nx = blk_mid;
    end

`ifdef DES_ENC_EN
    always_ff @(posedge clk) begin
        if (rst)
            fwd_q <= 1'b0;
        else if (state_q == S_IDLE && in_valid)
            fwd_q <= encrypt;
    end
`else
    assign fwd_q = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        unique case (state_q)
            S_IDLE:  if (in_valid) state_nx = S_ROUND;
            S_ROUND: if (last) state_nx = S_DONE;
            S_DONE:  if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_q    <= '0;
            cnt_q    <= '0;
            data_out <= '0;
        end else if (state_q == S_IDLE && in_valid) begin
            blk_q.l <= ip_o[31:0];
            blk_q.r <= ip_o[63:32];
            blk_q.c <= pc1_o[27:0];
            blk_q.d <= pc1_o[55:28];
            cnt_q   <= '0;
        end else if (state_q == S_ROUND) begin
            blk_q <= blk_nx;
            cnt_q <= cnt_q + 4'(RPC);
            // Preoutput is R16||L16: R16 occupies DES bits 1..32.
            if (last)
                data_out <= perm_ipinv({blk_nx.l, blk_nx.r});
        end
    end

endmodule

// File: tb/tb_des_decrypt_core.sv
// tb_des_decrypt_core: directed DES known-answer vectors against RPC=1 and RPC=2 cores.
// Vectors are written in standard DES hex order and bit-reversed onto the ports.
module tb_des_decrypt_core;

    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] C1 = 64'h85E813540F0AB405;
    localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] K2 = 64'h0101010101010101;
    localparam logic [63:0] C2 = 64'h95F8A5E5DD31D900;
    localparam logic [63:0] P2 = 64'h8000000000000000;
    localparam logic [63:0] K3 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] C3 = 64'h0000000000000000;
    localparam logic [63:0] P3 = 64'h8787878787878787;
    localparam logic [63:0] K4 = 64'h0123456789ABCDEF;
    localparam logic [63:0] C4 = 64'h3FA40E8A984D4815;
    localparam logic [63:0] P4 = 64'h4E6F772069732074;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] data_in;
    logic [63:0] key_in;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] data_out;
    logic        in_ready2;
    logic        out_valid2;
    logic [63:0] data_out2;
`ifdef DES_ENC_EN
    logic        encrypt;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    des_decrypt_core #(.RPC(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .key_in(key_in),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef DES_ENC_EN
        .encrypt(encrypt),
`endif
        .data_out(data_out)
    );

    des_decrypt_core #(.RPC(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready2),
        .data_in(data_in), .key_in(key_in),
        .out_valid(out_valid2), .out_ready(out_ready),
`ifdef DES_ENC_EN
        .encrypt(encrypt),
`endif
        .data_out(data_out2)
    );

    function automatic logic [63:0] rev(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[i] = x[63-i];
        return y;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] k, input logic [63:0] d, output bit ok);
        int n;
        key_in   = rev(k);
        data_in  = rev(d);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        ok = in_ready;
        tick();
        in_valid = 1'b0;
    endtask

    // rel counts cycles from the accept cycle (cycle 0).
    task automatic wait_out(output int rel, output bit ok);
        rel = 1;
        while (!out_valid && rel < 40) begin
            tick();
            rel++;
        end
        ok = out_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        tests++;
        if (data_out !== 64'h0) begin
            fails++;
            $display("FAIL reset_data_out: got %h expected 0", data_out);
        end
    endtask

    task automatic test_decrypt_basic();
        bit ok;
        int rel;
        out_ready = 1'b1;
        send(K1, C1, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL basic_accept: got no accept expected accept");
        end
        wait_out(rel, ok);
        tests++;
        if (rel !== 17) begin
            fails++;
            $display("FAIL basic_latency: got %0d expected 17", rel);
        end
        tests++;
        if (data_out !== rev(P1)) begin
            fails++;
            $display("FAIL basic_pt: got %h expected %h", rev(data_out), P1);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL basic_release: got ov=%b ir=%b expected ov=0 ir=1",
                     out_valid, in_ready);
        end
        tests++;
        if (data_out !== rev(P1)) begin
            fails++;
            $display("FAIL basic_retain: got %h expected %h", rev(data_out), P1);
        end
    endtask

    task automatic test_rpc2();
        bit ok;
        int l1;
        int l2;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        send(K2, C2, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL rpc2_accept: got no accept expected accept");
        end
        l1 = 0;
        l2 = 0;
        for (int r = 1; r <= 30; r++) begin
            if (out_valid && l1 == 0) l1 = r;
            if (out_valid2 && l2 == 0) l2 = r;
            if (r < 30) tick();
        end
        tests++;
        if (l1 !== 17) begin
            fails++;
            $display("FAIL rpc1_latency: got %0d expected 17", l1);
        end
        tests++;
        if (l2 !== 9) begin
            fails++;
            $display("FAIL rpc2_latency: got %0d expected 9", l2);
        end
        tests++;
        if (data_out !== rev(P2)) begin
            fails++;
            $display("FAIL rpc1_pt: got %h expected %h", rev(data_out), P2);
        end
        tests++;
        if (data_out2 !== rev(P2)) begin
            fails++;
            $display("FAIL rpc2_pt: got %h expected %h", rev(data_out2), P2);
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_backpressure();
        bit ok;
        int rel;
        out_ready = 1'b0;
        send(K1, C1, ok);
        wait_out(rel, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL bp_result: got no out_valid expected out_valid");
        end
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            data_in  = {$urandom, $urandom};
            key_in   = {$urandom, $urandom};
            tick();
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || data_out !== rev(P1)) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got ov=%b ir=%b pt=%h expected ov=1 ir=0 pt=%h",
                         i, out_valid, in_ready, rev(data_out), P1);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: got ov=%b ir=%b expected ov=0 ir=1",
                     out_valid, in_ready);
        end
        send(K2, C2, ok);
        wait_out(rel, ok);
        tests++;
        if (!ok || data_out !== rev(P2)) begin
            fails++;
            $display("FAIL bp_next: got %h expected %h", rev(data_out), P2);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int rel;
        out_ready = 1'b1;
        send(K2, C2, ok);
        repeat (6) tick();
        tests++;
        if (out_valid !== 1'b0 || data_out !== rev(P2)) begin
            fails++;
            $display("FAIL mid_before: got ov=%b pt=%h expected ov=0 pt=%h",
                     out_valid, rev(data_out), P2);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || data_out !== 64'h0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset: got ov=%b do=%h ir=%b expected ov=0 do=0 ir=1",
                     out_valid, data_out, in_ready);
        end
        send(K1, C1, ok);
        wait_out(rel, ok);
        tests++;
        if (rel !== 17 || data_out !== rev(P1)) begin
            fails++;
            $display("FAIL mid_fresh: got lat=%0d pt=%h expected lat=17 pt=%h",
                     rel, rev(data_out), P1);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [63:0] kv [4];
        logic [63:0] cv [4];
        logic [63:0] pv [4];
        int prev;
        int acc;
        int n;
        int rel;
        kv = '{K1, K2, K3, K4};
        cv = '{C1, C2, C3, C4};
        pv = '{P1, P2, P3, P4};
        prev = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int v = 0; v < 4; v++) begin
            key_in  = rev(kv[v]);
            data_in = rev(cv[v]);
            n = 0;
            while (!in_ready && n < 40) begin
                tick();
                n++;
            end
            tick();
            acc = cyc;
            if (v > 0) begin
                tests++;
                if (acc - prev !== 18) begin
                    fails++;
                    $display("FAIL b2b_spacing[%0d]: got %0d expected 18", v, acc - prev);
                end
            end
            prev = acc;
            rel = 1;
            while (!out_valid && rel < 40) begin
                if (rel == 5) key_in = ~key_in;
                if (rel == 10) data_in = ~data_in;
                tick();
                rel++;
            end
            tests++;
            if (out_valid !== 1'b1 || data_out !== rev(pv[v])) begin
                fails++;
                $display("FAIL b2b_pt[%0d]: got ov=%b pt=%h expected ov=1 pt=%h",
                         v, out_valid, rev(data_out), pv[v]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

`ifdef DES_ENC_EN
    task automatic test_encrypt();
        bit ok;
        int rel;
        logic [63:0] ct;
        out_ready = 1'b1;
        encrypt   = 1'b1;
        send(K1, P1, ok);
        wait_out(rel, ok);
        ct = rev(data_out);
        tests++;
        if (rel !== 17 || ct !== C1) begin
            fails++;
            $display("FAIL enc_ct: got lat=%0d ct=%h expected lat=17 ct=%h", rel, ct, C1);
        end
        tick();
        encrypt = 1'b0;
        send(K1, ct, ok);
        wait_out(rel, ok);
        tests++;
        if (data_out !== rev(P1)) begin
            fails++;
            $display("FAIL enc_roundtrip: got %h expected %h", rev(data_out), P1);
        end
        tick();
    endtask
`endif

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        key_in    = '0;
`ifdef DES_ENC_EN
        encrypt   = 1'b0;
`endif
        test_reset();
        test_decrypt_basic();
        test_rpc2();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef DES_ENC_EN
        test_encrypt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
